// File: rtl/bip_du_pkg.sv
// Shared constants and types for the BIP-I host debug unit.
// Command codes here are the defaults; the top can override them per instance.
package bip_du_pkg;

  localparam logic [7:0] DEF_CMD_LOAD = 8'h01;
  localparam logic [7:0] DEF_CMD_RUN  = 8'h02;
  localparam logic [7:0] DEF_CMD_STEP = 8'h03;
  localparam logic [7:0] DEF_ACK_BYTE = 8'hA5;

  localparam int REPORT_LEN = 6;
  localparam int REPORT_W   = 8 * REPORT_LEN;
  localparam int CYC_W      = 16;

  typedef enum logic [3:0] {
    IDLE,
    LD_CNT_H,
    LD_CNT_L,
    LD_HI,
    LD_LO,
    LD_WR,
    LD_ACK,
    RUN,
    STEP,
    REPORT
  } du_state_e;

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == {CYC_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bip_du_tx_seq.sv
// Byte sequencer toward the UART transmitter: sends either one byte or the
// 6-byte report word (MSB first), then pulses done once the last byte completes.
module bip_du_tx_seq
  import bip_du_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                single,
  input  logic [7:0]          byte_data,
  input  logic [REPORT_W-1:0] report_word,
  input  logic                tx_done,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  output logic                done
);

  logic [REPORT_W-1:0] shift_q;
  logic [2:0]          left_q;
  logic                busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      left_q   <= '0;
      busy_q   <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (go) begin
        busy_q   <= 1'b1;
        tx_start <= 1'b1;
        if (single) begin
          tx_data <= byte_data;
          shift_q <= '0;
          left_q  <= 3'd1;
        end else begin
          tx_data <= report_word[REPORT_W-1 -: 8];
          shift_q <= {report_word[REPORT_W-9:0], 8'h00};
          left_q  <= 3'(REPORT_LEN);
        end
      end else if (busy_q && tx_done && !tx_start) begin
        // A done that overlaps our own start pulse cannot belong to this byte.
        if (left_q == 3'd1) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end else begin
          tx_data  <= shift_q[REPORT_W-1 -: 8];
          shift_q  <= {shift_q[REPORT_W-9:0], 8'h00};
          left_q   <= left_q - 3'd1;
          tx_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bip_debug_unit.sv
// Host command decoder for the BIP-I core: program load, run-to-halt,
// single-step, and PC/ACC/cycle-count reporting over the UART byte interface.
module bip_debug_unit
  import bip_du_pkg::*;
#(
  parameter int         PM_ADDR_W = 11,
  parameter int         DATA_W    = 16,
  parameter logic [7:0] CMD_LOAD  = DEF_CMD_LOAD,
  parameter logic [7:0] CMD_RUN   = DEF_CMD_RUN,
  parameter logic [7:0] CMD_STEP  = DEF_CMD_STEP,
  parameter logic [7:0] ACK_BYTE  = DEF_ACK_BYTE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_pm_wr_en,
  output logic [PM_ADDR_W-1:0] o_pm_addr,
  output logic [DATA_W-1:0]    o_pm_data,
  output logic                 o_cpu_en,
  output logic                 o_cpu_rst,
  input  logic [PM_ADDR_W-1:0] i_cpu_pc,
  input  logic [DATA_W-1:0]    i_cpu_acc,
  input  logic                 i_cpu_halt
);

  // Handshakes: i_rx_done and i_tx_done are single-cycle strobes with no
  // backpressure; o_tx_start is a single-cycle strobe and o_tx_data is held
  // from that strobe until the matching i_tx_done.
  du_state_e state_q, state_d;

  logic [7:0]           cnt_hi_q;
  logic [7:0]           data_hi_q;
  logic [PM_ADDR_W-1:0] remain_q;
  logic [PM_ADDR_W-1:0] addr_q;
  logic [CYC_W-1:0]     cyc_q;
  logic                 seq_go_q;
  logic                 seq_single_q;
  logic                 seq_done;
  logic                 enter_tx;
  logic                 enter_ack;
  logic [15:0]          rx_word;
  logic [PM_ADDR_W-1:0] rx_count;
  logic [REPORT_W-1:0]  report_word;

  assign rx_word     = {cnt_hi_q, i_rx_data};
  assign rx_count    = rx_word[PM_ADDR_W-1:0];
  assign report_word = {16'(i_cpu_pc), 16'(i_cpu_acc), cyc_q};
  assign o_pm_addr   = addr_q;

  // Halt is combinational from the fetched opcode, so the enable must be
  // gated in the same cycle or the CPU would overrun past HALT.
  assign o_cpu_en = ((state_q == RUN) || (state_q == STEP)) && !i_cpu_halt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD)      state_d = LD_CNT_H;
          else if (i_rx_data == CMD_RUN)  state_d = RUN;
          else if (i_rx_data == CMD_STEP) state_d = STEP;
        end
      end
      LD_CNT_H: if (i_rx_done) state_d = LD_CNT_L;
      LD_CNT_L: if (i_rx_done) state_d = (rx_count == '0) ? LD_ACK : LD_HI;
      LD_HI:    if (i_rx_done) state_d = LD_LO;
      LD_LO:    if (i_rx_done) state_d = LD_WR;
      LD_WR:    state_d = (remain_q == PM_ADDR_W'(1)) ? LD_ACK : LD_HI;
      LD_ACK:   if (seq_done) state_d = IDLE;
      RUN:      if (i_cpu_halt) state_d = REPORT;
      STEP:     state_d = REPORT;
      REPORT:   if (seq_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign enter_ack = (state_d == LD_ACK) && (state_q != LD_ACK);
  assign enter_tx  = enter_ack || ((state_d == REPORT) && (state_q != REPORT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_hi_q     <= '0;
      data_hi_q    <= '0;
      remain_q     <= '0;
      addr_q       <= '0;
      cyc_q        <= '0;
      seq_go_q     <= 1'b0;
      seq_single_q <= 1'b0;
      o_pm_wr_en   <= 1'b0;
      o_pm_data    <= '0;
      o_cpu_rst    <= 1'b1;
    end else begin
      state_q      <= state_d;
      seq_go_q     <= enter_tx;
      seq_single_q <= (state_d == LD_ACK);
      o_cpu_rst    <= enter_ack;
      o_pm_wr_en   <= (state_q == LD_LO) && i_rx_done;
      case (state_q)
        IDLE:     if (i_rx_done && i_rx_data == CMD_LOAD) addr_q <= '0;
        LD_CNT_H: if (i_rx_done) cnt_hi_q <= i_rx_data;
        LD_CNT_L: if (i_rx_done) remain_q <= rx_count;
        LD_HI:    if (i_rx_done) data_hi_q <= i_rx_data;
        LD_LO:    if (i_rx_done) o_pm_data <= DATA_W'({data_hi_q, i_rx_data});
        LD_WR: begin
          addr_q   <= addr_q + 1'b1;
          remain_q <= remain_q - 1'b1;
        end
        RUN, STEP: if (!i_cpu_halt) cyc_q <= sat_inc(cyc_q);
        default: ;
      endcase
      // A completed load restarts the program, so its cycle count restarts too.
      if (enter_ack) cyc_q <= '0;
    end
  end

  bip_du_tx_seq u_tx_seq (
    .clk         (i_clk),
    .rst         (i_rst),
    .go          (seq_go_q),
    .single      (seq_single_q),
    .byte_data   (ACK_BYTE),
    .report_word (report_word),
    .tx_done     (i_tx_done),
    .tx_data     (o_tx_data),
    .tx_start    (o_tx_start),
    .done        (seq_done)
  );

endmodule

// File: tb/tb_bip_debug_unit.sv
// Bench for bip_debug_unit: host byte driver, UART tx responder, toy CPU
// model, and a reference model of the command protocol.
module tb_bip_debug_unit;
  import bip_du_pkg::*;

  localparam int AW = 11;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    i_rx_data = 8'h00;
  logic          i_rx_done = 1'b0;
  logic [7:0]    o_tx_data;
  logic          o_tx_start;
  logic          i_tx_done = 1'b0;
  logic          o_pm_wr_en;
  logic [AW-1:0] o_pm_addr;
  logic [DW-1:0] o_pm_data;
  logic          o_cpu_en;
  logic          o_cpu_rst;
  logic [AW-1:0] m_pc = '0;
  logic [15:0]   m_acc = '0;
  logic          i_cpu_halt;

  always #5 clk = ~clk;

  bip_debug_unit #(.PM_ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_pm_wr_en(o_pm_wr_en), .o_pm_addr(o_pm_addr), .o_pm_data(o_pm_data),
    .o_cpu_en(o_cpu_en), .o_cpu_rst(o_cpu_rst),
    .i_cpu_pc(m_pc), .i_cpu_acc(m_acc), .i_cpu_halt(i_cpu_halt)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- toy CPU: acc counts executed even PCs ----------------
  logic          halt_arm = 1'b0;
  logic          halt_force = 1'b0;
  logic [AW-1:0] halt_pc = '0;

  assign i_cpu_halt = halt_force | (halt_arm & (m_pc == halt_pc));

  always @(posedge clk) begin
    if (o_cpu_rst) begin
      m_pc  <= '0;
      m_acc <= '0;
    end else if (o_cpu_en) begin
      m_pc  <= m_pc + 1'b1;
      m_acc <= m_acc + {15'd0, ~m_pc[0]};
    end
  end

  // ---------------- observation ----------------
  logic [7:0]       exp_q[$];
  logic [7:0]       got_q[$];
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [AW+DW-1:0] wr_q[$];
  int en_cycles = 0;
  int rst_pulses = 0;

  always @(negedge clk) begin
    if (o_pm_wr_en === 1'b1) wr_q.push_back({o_pm_addr, o_pm_data});
    if (o_cpu_en === 1'b1) en_cycles++;
    if (o_cpu_rst === 1'b1 && !rst) rst_pulses++;
  end

  // UART transmitter stand-in: capture each started byte, finish it later.
  initial begin
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (o_tx_start === 1'b1) begin
        got_q.push_back(o_tx_data);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        i_tx_done = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  int ref_pc = 0;
  int ref_acc = 0;
  int ref_cyc = 0;

  task automatic ref_restart();
    ref_pc = 0; ref_acc = 0; ref_cyc = 0;
  endtask

  task automatic ref_exec(input int k);
    for (int i = 0; i < k; i++) begin
      if (ref_pc % 2 == 0) ref_acc = (ref_acc + 1) % 65536;
      ref_pc = (ref_pc + 1) % (1 << AW);
      if (ref_cyc < 65535) ref_cyc++;
    end
  endtask

  task automatic push_report();
    logic [15:0] p, a, c;
    p = 16'(ref_pc); a = 16'(ref_acc); c = 16'(ref_cyc);
    exp_q.push_back(p[15:8]); exp_q.push_back(p[7:0]);
    exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
    exp_q.push_back(c[15:8]); exp_q.push_back(c[7:0]);
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    send_byte(b);
    idle(3);
  endtask

  task automatic check_tx(input string name);
    int n;
    for (int i = 0; i < 3000 && got_q.size() < exp_q.size(); i++) @(negedge clk);
    idle(10);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s tx byte count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s tx byte %0d: got %02h, expected %02h", name, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_writes(input string name);
    int n;
    vectors++;
    if (wr_q.size() != exp_wr_q.size()) begin
      miscompares++;
      $display("FAIL %s write count: got %0d, expected %0d", name, wr_q.size(), exp_wr_q.size());
    end
    n = (wr_q.size() < exp_wr_q.size()) ? wr_q.size() : exp_wr_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (wr_q[i] !== exp_wr_q[i]) begin
        miscompares++;
        $display("FAIL %s write %0d: got addr %0h data %04h, expected addr %0h data %04h", name, i,
                 wr_q[i][AW+DW-1:DW], wr_q[i][DW-1:0], exp_wr_q[i][AW+DW-1:DW], exp_wr_q[i][DW-1:0]);
      end
    end
    wr_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (dut.state_q !== IDLE) begin
      miscompares++;
      $display("FAIL %s state: got %0d, expected IDLE", name, dut.state_q);
    end
  endtask

  // Load sequence; only the low AW bits of cnt decide how many words follow.
  logic [15:0] load_words[$];

  task automatic do_load(input string name, input logic [15:0] cnt);
    int n;
    logic [AW-1:0] a;
    n = int'(cnt[AW-1:0]);
    load_words.delete();
    for (int i = 0; i < n; i++) load_words.push_back(16'($urandom));
    do_load_words(name, cnt);
  endtask

  task automatic do_load_words(input string name, input logic [15:0] cnt);
    logic [AW-1:0] a;
    rst_pulses = 0;
    send_cmd(DEF_CMD_LOAD);
    send_cmd(cnt[15:8]);
    send_cmd(cnt[7:0]);
    a = '0;
    foreach (load_words[i]) begin
      send_cmd(load_words[i][15:8]);
      send_byte(load_words[i][7:0]);
      vectors++;
      if (o_pm_wr_en !== 1'b1) begin
        miscompares++;
        $display("FAIL %s wr_en timing word %0d: got %b, expected 1", name, i, o_pm_wr_en);
      end
      idle(3);
      exp_wr_q.push_back({a, load_words[i]});
      a = a + 1'b1;
    end
    exp_q.push_back(DEF_ACK_BYTE);
    ref_restart();
    check_tx(name);
    check_writes(name);
    vectors++;
    if (rst_pulses !== 1) begin
      miscompares++;
      $display("FAIL %s cpu_rst cycles: got %0d, expected 1", name, rst_pulses);
    end
    check_idle(name);
  endtask

  task automatic do_exec(input string name, input logic [7:0] cmd, input int k);
    en_cycles = 0;
    send_cmd(cmd);
    ref_exec(k);
    push_report();
    check_tx(name);
    vectors++;
    if (en_cycles !== k) begin
      miscompares++;
      $display("FAIL %s enabled cycles: got %0d, expected %0d", name, en_cycles, k);
    end
    check_idle(name);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle(4);
    vectors += 8;
    if (o_cpu_rst !== 1'b1)  begin miscompares++; $display("FAIL reset cpu_rst: got %b, expected 1", o_cpu_rst); end
    if (o_tx_start !== 1'b0) begin miscompares++; $display("FAIL reset tx_start: got %b, expected 0", o_tx_start); end
    if (o_pm_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset pm_wr_en: got %b, expected 0", o_pm_wr_en); end
    if (o_cpu_en !== 1'b0)   begin miscompares++; $display("FAIL reset cpu_en: got %b, expected 0", o_cpu_en); end
    if (o_tx_data !== 8'h00) begin miscompares++; $display("FAIL reset tx_data: got %02h, expected 00", o_tx_data); end
    if (o_pm_addr !== '0)    begin miscompares++; $display("FAIL reset pm_addr: got %0h, expected 0", o_pm_addr); end
    if (o_pm_data !== '0)    begin miscompares++; $display("FAIL reset pm_data: got %04h, expected 0", o_pm_data); end
    if (dut.cyc_q !== '0)    begin miscompares++; $display("FAIL reset cycle count: got %0h, expected 0", dut.cyc_q); end
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_cpu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL reset release cpu_rst: got %b, expected 0", o_cpu_rst);
    end
    ref_restart();
    idle(2);
  endtask

  task automatic test_load();
    load_words.delete();
    load_words.push_back(16'h0801);
    load_words.push_back(16'h1001);
    do_load_words("load_directed", 16'h0002);
    for (int t = 0; t < 3; t++) do_load("load_random", 16'($urandom_range(1, 5)));
  endtask

  task automatic test_load_zero();
    do_load("load_zero", 16'h0000);
    do_load("load_count_truncated", 16'h0800);
  endtask

  task automatic test_run();
    int k;
    do_load("run_setup", 16'h0001);
    halt_arm = 1'b1;
    halt_pc  = 11'd5;
    do_exec("run_directed", DEF_CMD_RUN, 5);
    for (int t = 0; t < 3; t++) begin
      k = int'($urandom_range(1, 40));
      halt_pc = AW'((ref_pc + k) % (1 << AW));
      do_exec("run_random", DEF_CMD_RUN, k);
    end
    halt_arm = 1'b0;
  endtask

  task automatic test_run_halted();
    do_load("halted_setup", 16'h0000);
    halt_force = 1'b1;
    do_exec("run_halted", DEF_CMD_RUN, 0);
    halt_force = 1'b0;
  endtask

  task automatic test_step();
    do_load("step_setup", 16'h0000);
    halt_arm = 1'b0;
    do_exec("step_1", DEF_CMD_STEP, 1);
    do_exec("step_2", DEF_CMD_STEP, 1);
    halt_arm = 1'b1;
    halt_pc  = AW'(ref_pc);
    do_exec("step_on_halt", DEF_CMD_STEP, 0);
    halt_arm = 1'b0;
  endtask

  task automatic test_unknown();
    en_cycles = 0;
    send_cmd(8'h7F);
    for (int i = 0; i < 4; i++) send_cmd(8'($urandom_range(4, 255)));
    idle(30);
    check_tx("unknown_cmd");
    check_writes("unknown_cmd");
    vectors++;
    if (en_cycles !== 0) begin
      miscompares++;
      $display("FAIL unknown_cmd enabled cycles: got %0d, expected 0", en_cycles);
    end
    check_idle("unknown_cmd");
  endtask

  task automatic test_reset_mid_load();
    send_cmd(DEF_CMD_LOAD);
    send_cmd(8'h00);
    send_cmd(8'h01);
    send_byte(8'hAB);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    ref_restart();
    idle(3);
    check_writes("reset_mid_load");
    check_tx("reset_mid_load");
    check_idle("reset_mid_load");
    vectors++;
    if (o_cpu_en !== 1'b0 || o_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_load outputs: got cpu_en %b tx_start %b, expected 0 0", o_cpu_en, o_tx_start);
    end
    do_load("load_after_reset", 16'h0001);
  endtask

  task automatic test_saturation();
    do_load("sat_setup", 16'h0000);
    halt_arm = 1'b0;
    en_cycles = 0;
    send_cmd(DEF_CMD_RUN);
    send_cmd(DEF_CMD_LOAD);
    send_cmd(8'h00);
    send_cmd(DEF_CMD_STEP);
    send_cmd(8'h5A);
    idle(67000);
    vectors++;
    if (got_q.size() != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL sat dropped bytes: got %0d tx and %0d writes, expected 0 0", got_q.size(), wr_q.size());
    end
    halt_force = 1'b1;
    ref_pc  = int'(m_pc);
    ref_acc = int'(m_acc);
    ref_cyc = (en_cycles > 65535) ? 65535 : en_cycles;
    vectors++;
    if (en_cycles <= 65535) begin
      miscompares++;
      $display("FAIL sat run length: got %0d enabled cycles, expected more than 65535", en_cycles);
    end
    push_report();
    check_tx("saturation");
    check_idle("saturation");
    halt_force = 1'b0;
  endtask

  initial begin
    #2ms;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 2ms");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_load_zero();
    test_run();
    test_run_halted();
    test_step();
    test_unknown();
    test_reset_mid_load();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
